// File: rtl/rr_burst_mux_pkg.sv
// Shared definitions for the round-robin burst mux: FSM encodings and a
// constant-width helper used to size counters from parameters.
package rr_burst_mux_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((32'sd1 <<< r) < n) begin
                r = r + 1;
            end else begin
                r = r;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_burst_mux_pick.sv
// Combinational wrap-around search: first asserted request at or after
// start_idx (or from index 0 when fixed priority is selected).
module rr_pick
    import rr_burst_mux_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = 2
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] start_idx,
    input  logic            prio_mode,
    output logic            found,
    output logic [SELW-1:0] idx
);

    // Scan NCH candidates starting at the base index, keeping the first hit.
    always_comb begin
        int base_s;
        int cand_s;
        found  = 1'b0;
        idx    = {SELW{1'b0}};
        base_s = prio_mode ? 0 : int'(start_idx);
        cand_s = 0;
        for (int k = 0; k < NCH; k++) begin
            cand_s = (base_s + k >= NCH) ? (base_s + k - NCH) : (base_s + k);
            if (!found && req[cand_s]) begin
                found = 1'b1;
                idx   = SELW'(cand_s);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/rr_burst_mux.sv
// NCH-way arbiter onto one registered valid/ready output with round-robin or
// fixed-priority selection and burst locking of up to BURST beats per grant.
module rr_burst_mux
    import rr_burst_mux_pkg::*;
#(
    parameter int WIDTH = 19,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 prio_mode,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic [SELW-1:0]      out_sel,
    output logic [NCH-1:0]       grant
);

    localparam int BW = clog2(BURST + 1);

    logic [0:0]      state_r, state_s;
    logic [SELW-1:0] owner_r, owner_s;
    logic [BW-1:0]   beat_cnt_r, beat_cnt_s;
    logic [SELW-1:0] rr_last_r, rr_last_s;
    logic [WIDTH-1:0] data_s;
    logic            valid_s;
    logic [SELW-1:0] sel_s;
    logic [NCH-1:0]  grant_s;

    logic            load_s;
    logic            keep_s;
    logic [SELW-1:0] last_eff_s;
    logic [SELW-1:0] start_s;
    logic            found_s;
    logic [SELW-1:0] pick_s;
    logic [BW-1:0]   cnt_inc_s;

    // A releasing owner counts as the last winner so it is searched last.
    assign load_s     = !out_valid | out_ready;
    assign keep_s     = (state_r == ST_LOCK) && req[owner_r];
    assign last_eff_s = (state_r == ST_LOCK) ? owner_r : rr_last_r;
    assign start_s    = (last_eff_s == SELW'(NCH - 1)) ? {SELW{1'b0}} : (last_eff_s + SELW'(1));
    assign cnt_inc_s  = beat_cnt_r + BW'(1);

    rr_pick #(.NCH(NCH), .SELW(SELW)) u_pick (
        .req       (req),
        .start_idx (start_s),
        .prio_mode (prio_mode),
        .found     (found_s),
        .idx       (pick_s)
    );

    // Next-state: continue burst, arbitrate a new winner, or go empty.
    always_comb begin
        state_s    = state_r;
        owner_s    = owner_r;
        beat_cnt_s = beat_cnt_r;
        rr_last_s  = rr_last_r;
        data_s     = out_data;
        valid_s    = out_valid;
        sel_s      = out_sel;
        grant_s    = {NCH{1'b0}};
        if (load_s) begin
            if (keep_s) begin
                data_s     = din[owner_r*WIDTH +: WIDTH];
                sel_s      = owner_r;
                valid_s    = 1'b1;
                grant_s    = {{(NCH-1){1'b0}}, 1'b1} << owner_r;
                beat_cnt_s = cnt_inc_s;
                if (cnt_inc_s == BW'(BURST)) begin
                    rr_last_s = owner_r;
                    state_s   = ST_IDLE;
                end else begin
                    state_s   = ST_LOCK;
                end
            end else if (found_s) begin
                data_s     = din[pick_s*WIDTH +: WIDTH];
                sel_s      = pick_s;
                valid_s    = 1'b1;
                grant_s    = {{(NCH-1){1'b0}}, 1'b1} << pick_s;
                beat_cnt_s = BW'(1);
                if (BURST == 1) begin
                    rr_last_s = pick_s;
                    state_s   = ST_IDLE;
                end else begin
                    owner_s   = pick_s;
                    rr_last_s = last_eff_s;
                    state_s   = ST_LOCK;
                end
            end else begin
                valid_s   = 1'b0;
                rr_last_s = last_eff_s;
                state_s   = ST_IDLE;
            end
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            owner_r    <= {SELW{1'b0}};
            beat_cnt_r <= {BW{1'b0}};
            rr_last_r  <= SELW'(NCH - 1);
            out_data   <= {WIDTH{1'b0}};
            out_valid  <= 1'b0;
            out_sel    <= {SELW{1'b0}};
            grant      <= {NCH{1'b0}};
        end else begin
            state_r    <= state_s;
            owner_r    <= owner_s;
            beat_cnt_r <= beat_cnt_s;
            rr_last_r  <= rr_last_s;
            out_data   <= data_s;
            out_valid  <= valid_s;
            out_sel    <= sel_s;
            grant      <= grant_s;
        end
    end

endmodule

// File: tb/tb_rr_burst_mux.sv
// Directed and randomized bench for rr_burst_mux against a behavioural model.
module tb_rr_burst_mux;

    localparam int WIDTH = 19;
    localparam int NCH   = 4;
    localparam int SELW  = 2;
    localparam int BURST = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 prio_mode = 1'b0;
    logic [NCH-1:0]       req = '0;
    logic [NCH*WIDTH-1:0] din = '0;
    logic                 out_ready = 1'b0;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic [SELW-1:0]      out_sel;
    logic [NCH-1:0]       grant;

    int checks = 0;
    int errors = 0;

    // Behavioural model: owner = -1 when nobody holds the bus.
    int             m_owner;
    int             m_beats;
    int             m_last;
    logic [WIDTH-1:0] m_data;
    logic           m_valid;
    int             m_sel;
    logic [NCH-1:0] m_grant;

    rr_burst_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .BURST(BURST)) dut (
        .clk       (clk),
        .reset     (reset),
        .prio_mode (prio_mode),
        .req       (req),
        .din       (din),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_last  = NCH - 1;
        m_data  = '0;
        m_valid = 1'b0;
        m_sel   = 0;
        m_grant = '0;
    endtask

    function automatic int search(input logic [NCH-1:0] r, input logic pm, input int last);
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = pm ? k : (last + 1 + k) % NCH;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        int w;
        m_grant = '0;
        if (!m_valid || out_ready) begin
            w = -1;
            if (m_owner >= 0 && req[m_owner]) begin
                w = m_owner;
                m_beats++;
            end else begin
                if (m_owner >= 0) m_last = m_owner;
                m_owner = -1;
                w = search(req, prio_mode, m_last);
                if (w >= 0) begin
                    m_owner = w;
                    m_beats = 1;
                end
            end
            if (w >= 0) begin
                m_data  = din[w*WIDTH +: WIDTH];
                m_sel   = w;
                m_valid = 1'b1;
                m_grant[w] = 1'b1;
                if (m_beats == BURST) begin
                    m_last  = w;
                    m_owner = -1;
                end
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check("data",  32'(out_data),  32'(m_data));
        check("valid", 32'(out_valid), 32'(m_valid));
        check("sel",   32'(out_sel),   32'(m_sel));
        check("grant", 32'(grant),     32'(m_grant));
    endtask

    task automatic cycle(input logic [NCH-1:0] r, input logic rdy);
        @(negedge clk);
        req       = r;
        out_ready = rdy;
        din       = (NCH*WIDTH)'({$urandom(), $urandom(), $urandom()});
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Asynchronous reset between edges; outputs must clear immediately.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        req   = '0;
        #1;
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sel",   32'(out_sel),   32'd0);
        check("rst_grant", 32'(grant),     32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        int exp3[9];
        int exp6[5];
        exp3 = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        exp6 = '{1, 1, 1, 1, 0};
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Mid-stream reset, then first RR grant goes to ch0.
        for (int i = 0; i < 6; i++) cycle(4'b1111, 1'b1);
        do_reset();
        cycle(4'b1111, 1'b1);
        check("t1_first_sel", 32'(out_sel), 32'd0);

        // Burst of four per channel with two requesters.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(4'b0011, 1'b1);
            check("t3_sel", 32'(out_sel), 32'(exp3[i]));
        end

        // Stall: output held while din keeps changing.
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            cycle(4'b0011, 1'b0);
            check("t4_hold", 32'(out_data), 32'(held));
            check("t4_nogrant", 32'(grant), 32'd0);
        end
        cycle(4'b0011, 1'b1);

        // Early release of ch2 hands over to ch3 with no bubble.
        do_reset();
        cycle(4'b0100, 1'b1);
        cycle(4'b0100, 1'b1);
        cycle(4'b1000, 1'b1);
        check("t5_sel", 32'(out_sel), 32'd3);
        check("t5_valid", 32'(out_valid), 32'd1);

        // Fixed priority: ch1 burst, then ch0 wins, then idle.
        do_reset();
        prio_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle((i < 4) ? 4'b1010 : 4'b1011, 1'b1);
            check("t6_sel", 32'(out_sel), 32'(exp6[i]));
        end
        cycle(4'b0000, 1'b1);
        check("t6_idle", 32'(out_valid), 32'd0);

        // Randomized traffic with back-pressure and mode changes.
        prio_mode = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 31) == 0) prio_mode = ~prio_mode;
            if ($urandom_range(0, 149) == 0) do_reset();
            cycle(NCH'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
